// File: rtl/pc_if.sv
// pc_if: command/status bundle between a controller (master) and program_counter (slave).
interface pc_if #(
  parameter int WIDTH = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  logic en;
  logic [2:0] cmd;
  logic [WIDTH-1:0] data_in;
  logic clr_err;
  logic [WIDTH-1:0] pc_out;
  logic [SPW-1:0] sp;
  logic stack_full;
  logic stack_empty;
  logic ovf;
  logic unf;
  modport master (
    output en, cmd, data_in, clr_err,
    input pc_out, sp, stack_full, stack_empty, ovf, unf
  );
  modport slave (
    input en, cmd, data_in, clr_err,
    output pc_out, sp, stack_full, stack_empty, ovf, unf
  );
endinterface

// File: rtl/program_counter.sv
// program_counter: registered PC with inc/jump/relative branch and call/return through a LIFO stack.
// Ports: clk (rising edge), reset (async, active low),
//   bus.slave: en, cmd, data_in, clr_err in; pc_out, sp, stack_full, stack_empty, ovf, unf out.
module program_counter #(
  parameter int WIDTH = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] C_INC = 3'd1;
  localparam logic [2:0] C_JMP = 3'd2;
  localparam logic [2:0] C_BRA = 3'd3;
  localparam logic [2:0] C_CALL = 3'd4;
  localparam logic [2:0] C_RET = 3'd5;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [SPW-1:0] r_sp;
  logic r_ovf;
  logic r_unf;
  logic w_full;
  logic w_empty;
  logic w_call;
  logic w_ret;
  logic w_push;
  logic w_pop;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [SPW-1:0] w_sp_nxt;
  always_comb begin
    w_full = r_sp == SPW'(STACK_DEPTH);
    w_empty = r_sp == '0;
    w_call = bus.en && bus.cmd == C_CALL;
    w_ret = bus.en && bus.cmd == C_RET;
    w_push = w_call && !w_full;
    w_pop = w_ret && !w_empty;
    w_wr_idx = AW'(r_sp);
    w_rd_idx = AW'(r_sp - 1'b1);
    w_pc_inc = r_pc + 1'b1;
    w_top = r_stack[w_rd_idx];
    // Adding the raw offset modulo 2^WIDTH is the same as adding its sign extension.
    w_pc_nxt = !bus.en ? r_pc :
               bus.cmd == C_INC ? w_pc_inc :
               bus.cmd == C_JMP ? bus.data_in :
               bus.cmd == C_BRA ? w_pc_inc + bus.data_in :
               w_push ? bus.data_in :
               w_pop ? w_top : r_pc;
    w_sp_nxt = w_push ? r_sp + 1'b1 : w_pop ? r_sp - 1'b1 : r_sp;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_VECTOR;
      r_sp <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      r_sp <= w_sp_nxt;
      if (w_push) r_stack[w_wr_idx] <= w_pc_inc;
      // A new error outranks a clear in the same cycle.
      r_ovf <= (w_call && w_full) || (r_ovf && !bus.clr_err);
      r_unf <= (w_ret && w_empty) || (r_unf && !bus.clr_err);
    end
  end
  assign bus.pc_out = r_pc;
  assign bus.sp = r_sp;
  assign bus.stack_full = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.ovf = r_ovf;
  assign bus.unf = r_unf;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed scoreboard bench for program_counter.
module tb_program_counter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  event chk_ev;
  typedef struct {
    logic [14:0] v;
    string nm;
  } exp_t;
  exp_t q[$];
  pc_if #(.WIDTH(8), .STACK_DEPTH(4)) bus ();
  program_counter #(.WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(8'h00)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [14:0] pk(input logic [7:0] pc, input logic [2:0] sp, input logic ovf, input logic unf);
    return {pc, sp, sp == 3'd4, sp == 3'd0, ovf, unf};
  endfunction
  task automatic expect_now(input logic [7:0] pc, input logic [2:0] sp, input logic ovf, input logic unf, input string nm);
    exp_t e;
    e.v = pk(pc, sp, ovf, unf);
    e.nm = nm;
    q.push_back(e);
  endtask
  task automatic step(input logic e, input logic [2:0] c, input logic [7:0] d, input logic clr,
                      input logic [7:0] pc, input logic [2:0] sp, input logic ovf, input logic unf, input string nm);
    @(negedge clk);
    bus.en = e;
    bus.cmd = c;
    bus.data_in = d;
    bus.clr_err = clr;
    expect_now(pc, sp, ovf, unf, nm);
  endtask
  initial begin
    exp_t e;
    logic [14:0] a;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        a = {bus.pc_out, bus.sp, bus.stack_full, bus.stack_empty, bus.ovf, bus.unf};
        n_run++;
        if (a !== e.v)
          begin
            n_fail++;
            $display("FAIL %s: got pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                     e.nm, a[14:7], a[6:4], a[3], a[2], a[1], a[0], e.v[14:7], e.v[6:4], e.v[3], e.v[2], e.v[1], e.v[0]);
          end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
  initial begin
    bus.en = 1'b0;
    bus.cmd = 3'd0;
    bus.data_in = 8'h00;
    bus.clr_err = 1'b0;
    #1;
    expect_now(8'h00, 3'd0, 1'b0, 1'b0, "async_reset_t0");
    -> chk_ev;
    repeat (3) step(1'b1, 3'd1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "held_in_reset");
    @(negedge clk);
    reset = 1'b1;
    bus.en = 1'b0;
    step(1, 3'd1, 8'h00, 0, 8'h01, 0, 0, 0, "inc1");
    step(1, 3'd1, 8'h00, 0, 8'h02, 0, 0, 0, "inc2");
    step(1, 3'd1, 8'h00, 0, 8'h03, 0, 0, 0, "inc3");
    step(1, 3'd2, 8'hFE, 0, 8'hFE, 0, 0, 0, "jmp_fe");
    step(1, 3'd1, 8'h00, 0, 8'hFF, 0, 0, 0, "inc_ff");
    step(1, 3'd1, 8'h00, 0, 8'h00, 0, 0, 0, "inc_wrap");
    step(1, 3'd2, 8'h10, 0, 8'h10, 0, 0, 0, "jmp_10");
    step(1, 3'd3, 8'hF0, 0, 8'h01, 0, 0, 0, "bra_back");
    step(1, 3'd2, 8'h02, 0, 8'h02, 0, 0, 0, "jmp_02");
    step(1, 3'd3, 8'hFC, 0, 8'hFF, 0, 0, 0, "bra_neg_wrap");
    step(1, 3'd3, 8'h05, 0, 8'h05, 0, 0, 0, "bra_fwd");
    step(1, 3'd0, 8'h77, 0, 8'h05, 0, 0, 0, "nop");
    step(1, 3'd6, 8'h77, 0, 8'h05, 0, 0, 0, "rsv6");
    step(1, 3'd7, 8'h77, 0, 8'h05, 0, 0, 0, "rsv7");
    step(1, 3'd2, 8'h20, 0, 8'h20, 0, 0, 0, "jmp_20");
    step(1, 3'd4, 8'h40, 0, 8'h40, 1, 0, 0, "call40");
    step(1, 3'd4, 8'h50, 0, 8'h50, 2, 0, 0, "call50");
    step(1, 3'd4, 8'h60, 0, 8'h60, 3, 0, 0, "call60");
    step(1, 3'd4, 8'h70, 0, 8'h70, 4, 0, 0, "call70_full");
    step(1, 3'd4, 8'h80, 0, 8'h70, 4, 1, 0, "call80_ovf");
    step(1, 3'd5, 8'h00, 0, 8'h61, 3, 1, 0, "ret61");
    step(1, 3'd5, 8'h00, 0, 8'h51, 2, 1, 0, "ret51");
    step(1, 3'd5, 8'h00, 0, 8'h41, 1, 1, 0, "ret41");
    step(1, 3'd5, 8'h00, 0, 8'h21, 0, 1, 0, "ret21_empty");
    step(1, 3'd5, 8'h00, 0, 8'h21, 0, 1, 1, "ret_unf");
    step(0, 3'd0, 8'h00, 1, 8'h21, 0, 0, 0, "clr_alone");
    step(1, 3'd5, 8'h00, 1, 8'h21, 0, 0, 1, "clr_vs_unf");
    step(0, 3'd0, 8'h00, 1, 8'h21, 0, 0, 0, "clr_again");
    for (int i = 0; i < 5; i++) step(0, 3'd1, 8'h00, 0, 8'h21, 0, 0, 0, "en_low_hold");
    step(1, 3'd2, 8'hFF, 0, 8'hFF, 0, 0, 0, "jmp_ff");
    step(1, 3'd4, 8'h30, 0, 8'h30, 1, 0, 0, "call_at_ff");
    step(1, 3'd5, 8'h00, 0, 8'h00, 0, 0, 0, "ret_wrapped");
    step(1, 3'd4, 8'h44, 0, 8'h44, 1, 0, 0, "call44");
    step(1, 3'd5, 8'h00, 0, 8'h01, 0, 0, 0, "ret_b2b");
    step(1, 3'd2, 8'h05, 0, 8'h05, 0, 0, 0, "jmp_05");
    step(1, 3'd4, 8'h10, 0, 8'h10, 1, 0, 0, "call10");
    step(1, 3'd4, 8'h20, 0, 8'h20, 2, 0, 0, "call20");
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.en = 1'b0;
    #1;
    expect_now(8'h00, 3'd0, 1'b0, 1'b0, "async_mid_reset");
    -> chk_ev;
    @(negedge clk);
    reset = 1'b1;
    step(1, 3'd5, 8'h00, 0, 8'h00, 0, 0, 1, "ret_after_reset");
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/program_counter.md
# program_counter

Registered program counter for the BasicCPU datapath, built on the same single-clock, asynchronously reset flip-flop style as the core storage cells. It holds the current instruction address and drives the memory address path. Each enabled cycle it increments, jumps, branches relatively, or calls/returns through a small internal return-address stack. Overflow and underflow of that stack are reported on sticky error flags.

## Interface
- WIDTH, 8: address width in bits.
- STACK_DEPTH, 4: return-stack entries; must be ≥1.
- RESET_VECTOR, 0: value loaded into pc_out on reset.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  command strobe; when low all state holds regardless of cmd.
- cmd  in  3  operation select, sampled when en=1.
- data_in  in  WIDTH  jump/call target, or signed branch offset.
- clr_err  in  1  synchronous clear of the sticky error flags.
- pc_out  out  WIDTH  current program counter, registered.
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries, 0..STACK_DEPTH.
- stack_full  out  1  combinational; high when sp==STACK_DEPTH.
- stack_empty  out  1  combinational; high when sp==0.
- ovf  out  1  sticky; set by a CALL issued while the stack is full.
- unf  out  1  sticky; set by a RET issued while the stack is empty.

## Operation
- cmd encoding, applied only when en=1:
  - 0 NOP.
  - 1 INC: pc = pc+1.
  - 2 JMP: pc = data_in.
  - 3 BRA: pc = pc+1+sext(data_in), where data_in is two's complement.
  - 4 CALL: push pc+1, then pc = data_in.
  - 5 RET: pop the top entry into pc.
  - 6 and 7 are reserved and behave as NOP.
- Arithmetic is modulo 2^WIDTH and wraps silently.
  - WIDTH=8: INC from 0xFF gives 0x00.
  - WIDTH=8: BRA with pc=0x02 and data_in=0xFC gives 0xFF.
- The stack is LIFO and holds STACK_DEPTH entries.
  - Push writes entry[sp], then sp = sp+1.
  - Pop reads entry[sp-1], then sp = sp-1.
- CALL while stack_full: pc, sp and stack contents are unchanged; ovf is set.
- RET while stack_empty: pc and sp are unchanged; unf is set.
- Pushed values wrap like any other arithmetic: CALL at pc=0xFF pushes 0x00.
- clr_err=1 clears ovf and unf on the next edge.
  - If a new error occurs in the same cycle, the set wins and the flag stays 1.
- clr_err works independently of en.
- No state machine beyond sp: the block is a pure registered datapath plus the stack pointer.

## Timing
- Every command takes effect at the rising clk edge on which en=1 is sampled. pc_out shows the result one cycle after the command is presented (latency 1).
- Back-to-back commands are allowed every cycle, with no stalls.
  - Example: CALL then RET on consecutive cycles returns pc to the pre-CALL pc+1.
- stack_full, stack_empty, ovf and unf reflect state after the same edge that updates pc_out.
- Reset (reset=0) acts immediately, without waiting for clk:
  - pc_out = RESET_VECTOR.
  - sp = 0, stack_empty = 1, stack_full = 0.
  - ovf = 0, unf = 0.
  - All stack entries = 0.
- Reset asserted mid-operation discards any in-flight command and all stacked return addresses.
- The first command is accepted on the first rising edge after reset is released, with no extra cycle.
- Inputs must be stable around the rising clk edge. The block does not synchronise en or cmd.

## Test plan
- Reset sequence: hold reset=0 for 3 cycles, then release; issue INC ×3 → pc_out reads 0x00 while in reset, then 0x01, 0x02, 0x03; sp=0.
- Jump, branch and wrap: JMP 0xFE, INC, INC → pc 0xFE, 0xFF, 0x00. Then JMP 0x10, BRA 0xF0 → pc 0x10, 0x01.
- Nested calls:
  - From pc=0x20, issue CALL 0x40, CALL 0x50, CALL 0x60, CALL 0x70 → sp=4, stack_full=1.
  - A fifth CALL 0x80 → pc stays 0x70, ovf=1, sp=4.
  - Four RETs → pc 0x61, 0x51, 0x41, 0x21; stack_empty=1.
- Underflow and clear:
  - RET with sp=0 → pc unchanged, unf=1.
  - clr_err=1 alone → unf=0.
  - clr_err=1 together with another empty RET → unf stays 1.
- Enable gating and mid-operation reset:
  - en=0 with cmd=INC for 5 cycles → pc constant.
  - After two CALLs, pulse reset=0 between clock edges → pc_out = RESET_VECTOR immediately, sp=0, and a following RET sets unf=1.
